wptr_full: RTL and testbench

WPTR_FULL -- requirements
Module: wptr_full

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/gray_cntr.sv | 36 +++
 rtl/wptr_full.sv | 86 ++++++++
 tb/tb_wptr_full.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the async FIFO write/read pointer blocks.
// Functions work on zero-extended 32-bit words, so any pointer width up to 32 fits.
package fifo_pkg;

  localparam int unsigned PTR_MAX_W = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_word_t;

  function automatic ptr_word_t bin2gray(input ptr_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Leading zeros of a zero-extended Gray word decode to zeros, so the
  // prefix-XOR from the top bit is correct for every narrower width.
  function automatic ptr_word_t gray2bin(input ptr_word_t g);
    ptr_word_t b;
    b = '0;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int unsigned i = PTR_MAX_W - 1; i > 0; i--) begin
      b[i-1] = b[i] ^ g[i-1];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_cntr.sv
// Binary/Gray pointer register pair shared by the FIFO write and read sides.
// reset is asynchronous and active-low.
module gray_cntr
  import fifo_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] bin,
  output logic [W-1:0] gray
);

  logic [W-1:0] bin_d, bin_q;
  logic [W-1:0] gray_d, gray_q;

  always_comb begin
    bin_d  = bin_q + W'(inc);
    gray_d = W'(bin2gray(ptr_word_t'(bin_d)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_q  <= '0;
      gray_q <= '0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
    end
  end

  assign bin  = bin_q;
  assign gray = gray_q;

endmodule

// File: rtl/wptr_full.sv
// Async FIFO write-side pointer and full-flag generator.
// Optional used-words / almost-full outputs enabled by macro WPTR_FULL_USEDW_EN.
module wptr_full
  import fifo_pkg::*;
#(
  parameter int unsigned AWIDTH    = 3,
  parameter int unsigned AFULL_VAL = 2**AWIDTH - 2
) (
  input  logic              clk_i,
  input  logic              aclr_n_i,
  input  logic              wrreq_i,
  input  logic [AWIDTH:0]   rd_pntr_gray_i,
  output logic              wr_en_o,
  output logic [AWIDTH-1:0] wr_addr_o,
  output logic [AWIDTH:0]   wr_pntr_gray_o,
  output logic              full_o,
  output logic [AWIDTH:0]   wrusedw_o,
  output logic              almost_full_o
);

  localparam int unsigned PW = AWIDTH + 1;
  // Full when the write Gray pointer equals the read one with its two MSBs flipped.
  localparam logic [PW-1:0] MSB2_MASK = PW'(3) << (PW - 2);

  logic [PW-1:0] wbin, wgray;
  logic [PW-1:0] wbin_next, wgray_next;
  logic          wr_en;
  logic          full_d, full_q;

  gray_cntr #(
    .W (PW)
  ) u_wcntr (
    .clk   (clk_i),
    .reset (aclr_n_i),
    .inc   (wr_en),
    .bin   (wbin),
    .gray  (wgray)
  );

  always_comb begin
    wr_en      = wrreq_i & ~full_q;
    wbin_next  = wbin + PW'(wr_en);
    wgray_next = PW'(bin2gray(ptr_word_t'(wbin_next)));
    full_d     = (wgray_next == (rd_pntr_gray_i ^ MSB2_MASK));
  end

  always_ff @(posedge clk_i or negedge aclr_n_i) begin
    if (!aclr_n_i) begin
      full_q <= 1'b0;
    end else begin
      full_q <= full_d;
    end
  end

`ifdef WPTR_FULL_USEDW_EN
  logic [PW-1:0] wrusedw_d, wrusedw_q;
  logic          afull_d, afull_q;

  always_comb begin
    wrusedw_d = wbin_next - PW'(gray2bin(ptr_word_t'(rd_pntr_gray_i)));
    afull_d   = (32'(wrusedw_d) >= AFULL_VAL);
  end

  always_ff @(posedge clk_i or negedge aclr_n_i) begin
    if (!aclr_n_i) begin
      wrusedw_q <= '0;
      afull_q   <= 1'b0;
    end else begin
      wrusedw_q <= wrusedw_d;
      afull_q   <= afull_d;
    end
  end

  assign wrusedw_o     = wrusedw_q;
  assign almost_full_o = afull_q;
`else
  assign wrusedw_o     = '0;
  assign almost_full_o = 1'b0;
`endif

  assign wr_en_o        = wr_en;
  assign wr_addr_o      = wbin[AWIDTH-1:0];
  assign wr_pntr_gray_o = wgray;
  assign full_o         = full_q;

endmodule

// File: tb/tb_wptr_full.sv
// Self-checking bench for wptr_full (AWIDTH=3): directed vector table,
// hand sequences for reset/wrap/used-words, and a randomized run against an occupancy model.
module tb_wptr_full;

  localparam int unsigned AW = 3;

  logic          clk_i = 1'b0;
  logic          aclr_n_i;
  logic          wrreq_i;
  logic [AW:0]   rd_pntr_gray_i;
  logic          wr_en_o;
  logic [AW-1:0] wr_addr_o;
  logic [AW:0]   wr_pntr_gray_o;
  logic          full_o;
  logic [AW:0]   wrusedw_o;
  logic          almost_full_o;

  wptr_full #(
    .AWIDTH    (AW),
    .AFULL_VAL (6)
  ) dut (
    .clk_i          (clk_i),
    .aclr_n_i       (aclr_n_i),
    .wrreq_i        (wrreq_i),
    .rd_pntr_gray_i (rd_pntr_gray_i),
    .wr_en_o        (wr_en_o),
    .wr_addr_o      (wr_addr_o),
    .wr_pntr_gray_o (wr_pntr_gray_o),
    .full_o         (full_o),
    .wrusedw_o      (wrusedw_o),
    .almost_full_o  (almost_full_o)
  );

  always #5 clk_i = ~clk_i;

  int vecs = 0;
  int mis  = 0;

  // Model: count of accepted writes and last sampled read pointer, both mod 16.
  int m_w = 0;
  int m_r = 0;
  bit m_full = 1'b0;

  typedef struct {
    bit          wr;
    int          rb;
    bit          exp_en;
    bit          exp_full;
    logic [3:0]  exp_gray;
    logic [2:0]  exp_addr;
  } vec_t;

  vec_t tbl[13];

  function automatic int g(input int b);
    return (b ^ (b >> 1)) & 15;
  endfunction

  function automatic int m_used();
`ifdef WPTR_FULL_USEDW_EN
    return (m_w - m_r) & 15;
`else
    return 0;
`endif
  endfunction

  function automatic int m_af();
`ifdef WPTR_FULL_USEDW_EN
    return (((m_w - m_r) & 15) >= 6) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drives one cycle from edge+1; returns sampled and expected wr_en; ends at next edge+1.
  task automatic apply(input bit wr, input int rb, output bit en_seen, output bit en_exp);
    wrreq_i        = wr;
    rd_pntr_gray_i = 4'(g(rb));
    #1;
    en_seen = wr_en_o;
    en_exp  = wr && !m_full;
    @(posedge clk_i);
    if (en_exp) m_w = (m_w + 1) & 15;
    m_r    = rb & 15;
    m_full = (((m_w - m_r) & 15) == 8);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_addr"},  32'(wr_addr_o),      32'(m_w & 7));
    chk({tag, "_gray"},  32'(wr_pntr_gray_o), 32'(g(m_w)));
    chk({tag, "_full"},  32'(full_o),         32'(m_full));
    chk({tag, "_usedw"}, 32'(wrusedw_o),      32'(m_used()));
    chk({tag, "_afull"}, 32'(almost_full_o),  32'(m_af()));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_addr0"},  32'(wr_addr_o),      32'd0);
    chk({tag, "_gray0"},  32'(wr_pntr_gray_o), 32'd0);
    chk({tag, "_full0"},  32'(full_o),         32'd0);
    chk({tag, "_usedw0"}, 32'(wrusedw_o),      32'd0);
    chk({tag, "_afull0"}, 32'(almost_full_o),  32'd0);
  endtask

  // Assert reset 2 time units after an edge and release it 2 units after the next.
  task automatic pulse_reset(input string tag);
    #1;
    aclr_n_i = 1'b0;
    #1;
    check_zero(tag);
    m_w = 0; m_r = 0; m_full = 1'b0;
    @(posedge clk_i);
    #2;
    aclr_n_i = 1'b1;
  endtask

  initial begin
    bit en, en_x;
    logic [3:0] prev_g;
    int rb;

    // 8 writes to fill, 3 blocked writes, a read frees a slot, then refill.
    tbl[0]  = '{1, 0, 1, 0, 4'b0001, 3'd1};
    tbl[1]  = '{1, 0, 1, 0, 4'b0011, 3'd2};
    tbl[2]  = '{1, 0, 1, 0, 4'b0010, 3'd3};
    tbl[3]  = '{1, 0, 1, 0, 4'b0110, 3'd4};
    tbl[4]  = '{1, 0, 1, 0, 4'b0111, 3'd5};
    tbl[5]  = '{1, 0, 1, 0, 4'b0101, 3'd6};
    tbl[6]  = '{1, 0, 1, 0, 4'b0100, 3'd7};
    tbl[7]  = '{1, 0, 1, 1, 4'b1100, 3'd0};
    tbl[8]  = '{1, 0, 0, 1, 4'b1100, 3'd0};
    tbl[9]  = '{1, 0, 0, 1, 4'b1100, 3'd0};
    tbl[10] = '{1, 0, 0, 1, 4'b1100, 3'd0};
    tbl[11] = '{0, 1, 0, 0, 4'b1100, 3'd0};
    tbl[12] = '{1, 1, 1, 1, 4'b1101, 3'd1};

    aclr_n_i       = 1'b0;
    wrreq_i        = 1'b0;
    rd_pntr_gray_i = '0;
    #1;
    check_zero("por");
    #11;
    aclr_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    check_model("idle");

    for (int i = 0; i < 13; i++) begin
      apply(tbl[i].wr, tbl[i].rb, en, en_x);
      chk($sformatf("tbl%0d_wr_en", i), 32'(en),             32'(tbl[i].exp_en));
      chk($sformatf("tbl%0d_full", i),  32'(full_o),         32'(tbl[i].exp_full));
      chk($sformatf("tbl%0d_gray", i),  32'(wr_pntr_gray_o), 32'(tbl[i].exp_gray));
      chk($sformatf("tbl%0d_addr", i),  32'(wr_addr_o),      32'(tbl[i].exp_addr));
    end

    // 20 writes each matched by a read: pointer wraps, never full, one Gray bit per write.
    pulse_reset("rst_wrap");
    for (int i = 0; i < 20; i++) begin
      prev_g = wr_pntr_gray_o;
      apply(1'b1, m_w, en, en_x);
      chk($sformatf("wrap%0d_wr_en", i), 32'(en), 32'd1);
      chk($sformatf("wrap%0d_full", i), 32'(full_o), 32'd0);
      chk($sformatf("wrap%0d_gray_bits", i), 32'($countones(prev_g ^ wr_pntr_gray_o)), 32'd1);
      chk($sformatf("wrap%0d_gray", i), 32'(wr_pntr_gray_o), 32'(g(m_w)));
    end

    // Used words with read pointer at 1: 6 writes -> 5 used, 7th -> 6 and almost full.
    pulse_reset("rst_usedw");
    for (int i = 0; i < 6; i++) apply(1'b1, 1, en, en_x);
`ifdef WPTR_FULL_USEDW_EN
    chk("usedw_6w", 32'(wrusedw_o), 32'd5);
    chk("afull_6w", 32'(almost_full_o), 32'd0);
    apply(1'b1, 1, en, en_x);
    chk("usedw_7w", 32'(wrusedw_o), 32'd6);
    chk("afull_7w", 32'(almost_full_o), 32'd1);
`else
    chk("usedw_6w", 32'(wrusedw_o), 32'd0);
    chk("afull_6w", 32'(almost_full_o), 32'd0);
    apply(1'b1, 1, en, en_x);
    chk("usedw_7w", 32'(wrusedw_o), 32'd0);
    chk("afull_7w", 32'(almost_full_o), 32'd0);
`endif
    check_model("usedw_end");

    // Reset in the middle of a write burst, then resume at address 0.
    pulse_reset("rst_pre");
    for (int i = 0; i < 3; i++) apply(1'b1, 0, en, en_x);
    chk("burst_addr", 32'(wr_addr_o), 32'd3);
    pulse_reset("rst_burst");
    chk("post_rst_addr", 32'(wr_addr_o), 32'd0);
    apply(1'b1, 0, en, en_x);
    chk("post_rst_wr_en", 32'(en), 32'd1);
    chk("post_rst_addr1", 32'(wr_addr_o), 32'd1);
    chk("post_rst_gray1", 32'(wr_pntr_gray_o), 32'd1);

    // Random traffic: reads only advance while the model FIFO is non-empty.
    for (int i = 0; i < 400; i++) begin
      bit wr;
      wr = ($urandom_range(0, 9) < 7);
      rb = m_r;
      if (m_r != m_w && $urandom_range(0, 1) == 1) rb = (m_r + 1) & 15;
      apply(wr, rb, en, en_x);
      chk("rnd_wr_en", 32'(en), 32'(en_x));
      check_model("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
